mvu_rdc_reader: RTL and testbench
=================================

MVU_RDC_READER -- requirements
Module: mvu_rdc_reader

Interface
REQ-001 Parameter BDBANKA, default 15, data memory controller address width.
REQ-002 Parameter BDBANKW, default 64, data memory controller word width.
REQ-003 Parameter BLEN, default 16, burst length width.
REQ-004 Parameter RDLAT, default 2, fixed cycles from accepted request (rdc_en & rdc_grnt) to rdc_word valid, range 1-4.
REQ-005 Parameter DEPTH, default 8, output FIFO entries, power of two, at least RDLAT+1.
REQ-006 One clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cmd_valid  in  1  burst command offered.
REQ-010 cmd_ready  out  1  high only in IDLE.
REQ-011 cmd_base  in  BDBANKA  first read address.
REQ-012 cmd_jump  in  BDBANKA  address increment per word.
REQ-013 cmd_len  in  BLEN  number of words to read.
REQ-014 rdc_en  out  1  controller read request to MVU data memory.
REQ-015 rdc_addr  out  BDBANKA  controller read address.
REQ-016 rdc_grnt  in  1  MVU grant; request accepted when rdc_en & rdc_grnt.
REQ-017 rdc_word  in  BDBANKW  read data, valid RDLAT cycles after acceptance.
REQ-018 o_valid / o_ready  out / in  1 / 1  output stream handshake.
REQ-019 o_word  out  BDBANKW  FIFO head word.
REQ-020 o_last  out  1  head word is the final word of the burst.
REQ-021 done  out  1  one-cycle pulse when the burst completes.

Function
REQ-022 States: IDLE, ISSUE, DRAIN.
REQ-023 IDLE: cmd_valid & cmd_ready latches base, jump, len; len>0 -> ISSUE; len=0 -> IDLE with done pulse next cycle, no reads, no o_valid.
REQ-024 ISSUE: rdc_en=1 only when fifo_count + inflight < DEPTH; rdc_addr = base + k*jump mod 2^BDBANKA, k = accepted-request count.
REQ-025 rdc_addr and rdc_en hold stable until granted; rdc_grnt while rdc_en=0 is ignored.
REQ-026 On the len-th acceptance -> DRAIN; rdc_en=0 in the same cycle the transition takes effect.
REQ-027 Acceptances tracked by an RDLAT-deep valid shift register; rdc_word captured into the FIFO when the shift-register tail is set.
REQ-028 inflight = number of set shift-register bits; capacity check counts inflight, so the FIFO never overflows and no grant stalls on o_ready.
REQ-029 FIFO: push and pop in the same cycle permitted at full or empty; count unchanged; pointers wrap modulo DEPTH.
REQ-030 o_valid = FIFO non-empty; pop on o_valid & o_ready; o_word/o_valid held while o_ready=0.
REQ-031 o_last set on the word whose pop makes the popped-word total equal len.
REQ-032 DRAIN -> IDLE when that last word pops; done pulses the same cycle as that pop; cmd_ready high from the next cycle.
REQ-033 Minimum latency: acceptance at cycle t -> o_valid at t+RDLAT+1.
REQ-034 Commands offered outside IDLE are not accepted; cmd_ready=0.

Reset
REQ-035 rst_n=0 asynchronously forces: state IDLE, rdc_en=0, rdc_addr=0, o_valid=0, o_last=0, done=0, FIFO empty, shift register clear, counters 0; cmd_ready=1 after release.
REQ-036 Reset mid-burst discards in-flight returns; rdc_word arriving after release is not captured.

Verification
REQ-037 base=0x10, jump=1, len=4, grnt always 1, o_ready=1 -> addresses 0x10-0x13 on consecutive cycles, words out in order, o_last on the 4th, done once.
REQ-038 base=0x7FFE, jump=3, len=3 -> addresses 0x7FFE, 0x0001, 0x0004 (wrap).
REQ-039 len=20, DEPTH=8, o_ready=0 -> exactly 8 acceptances then rdc_en=0; o_ready=1 resumes; 20 words, no loss or duplicates.
REQ-040 grnt random 30%, o_ready random 50%, len=50 -> rdc_addr stable while ungranted; output matches memory model in order.
REQ-041 len=0 -> done pulse, rdc_en never high, o_valid never high.
REQ-042 rst_n low for 1 cycle after 3 of len=10 accepted -> all outputs to reset values; new len=2 burst returns only its 2 words.

Source files
------------

// File: rtl/mvu_rdc_reader.sv
// Burst reader for the MVU data memory: issues strided read requests under a credit
// check, realigns the fixed-latency returns through a valid pipe, and streams them out of a FIFO.
module mvu_rdc_reader #(
  parameter int BDBANKA = 15,
  parameter int BDBANKW = 64,
  parameter int BLEN    = 16,
  parameter int RDLAT   = 2,
  parameter int DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [BDBANKA-1:0] cmd_base,
  input  logic [BDBANKA-1:0] cmd_jump,
  input  logic [BLEN-1:0]    cmd_len,
  output logic               rdc_en,
  output logic [BDBANKA-1:0] rdc_addr,
  input  logic               rdc_grnt,
  input  logic [BDBANKW-1:0] rdc_word,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [BDBANKW-1:0] o_word,
  output logic               o_last,
  output logic               done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [BDBANKA-1:0]   r_addr, r_jump;
  logic [BLEN-1:0]      r_len, r_acc_cnt, r_pop_cnt;
  logic [RDLAT-1:0]     r_vld_pipe;
  logic                 r_zdone;
  logic [BDBANKW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;
  logic [CW:0]          w_occ;
  logic                 w_cmd_acc, w_acc, w_acc_last, w_push, w_pop, w_pop_last;

  // Occupancy = stored words plus requests still in flight, so a grant never outruns FIFO space.
  always_comb begin
    w_occ = {1'b0, r_count};
    for (int i = 0; i < RDLAT; i++) w_occ = w_occ + (CW+1)'(r_vld_pipe[i]);
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign w_cmd_acc  = cmd_valid & cmd_ready;
  assign rdc_en     = (r_state == S_ISSUE) && (w_occ < (CW+1)'(DEPTH));
  assign rdc_addr   = r_addr;
  assign w_acc      = rdc_en & rdc_grnt;
  assign w_acc_last = w_acc && (({1'b0, r_acc_cnt} + (BLEN+1)'(1)) == {1'b0, r_len});
  assign w_push     = r_vld_pipe[RDLAT-1];
  assign o_valid    = (r_count != '0);
  assign o_word     = r_mem[r_rptr];
  assign w_pop      = o_valid & o_ready;
  assign o_last     = o_valid && (({1'b0, r_pop_cnt} + (BLEN+1)'(1)) == {1'b0, r_len});
  assign w_pop_last = w_pop & o_last;
  assign done       = r_zdone | w_pop_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_acc && (cmd_len != '0)) w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_acc_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_jump     <= '0;
      r_len      <= '0;
      r_acc_cnt  <= '0;
      r_pop_cnt  <= '0;
      r_zdone    <= 1'b0;
      r_vld_pipe <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_zdone <= w_cmd_acc && (cmd_len == '0);
      if (w_cmd_acc) begin
        r_addr    <= cmd_base;
        r_jump    <= cmd_jump;
        r_len     <= cmd_len;
        r_acc_cnt <= '0;
        r_pop_cnt <= '0;
      end else begin
        if (w_acc) begin
          r_addr    <= r_addr + r_jump;
          r_acc_cnt <= r_acc_cnt + BLEN'(1);
        end
        if (w_pop) r_pop_cnt <= r_pop_cnt + BLEN'(1);
      end
      r_vld_pipe[0] <= w_acc;
      for (int i = 1; i < RDLAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is owned by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rdc_word;
  end

endmodule

// File: tb/tb_mvu_rdc_reader.sv
// Directed bench for mvu_rdc_reader: a fixed-latency memory responder plus per-cycle
// checks of address sequence, request stability, output order, o_last and done.
module tb_mvu_rdc_reader;
  localparam int RDLAT = 2;
  localparam int DEPTH = 8;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [14:0] cmd_base, cmd_jump;
  logic [15:0] cmd_len;
  logic        rdc_en, rdc_grnt;
  logic [14:0] rdc_addr;
  logic [63:0] rdc_word;
  logic        o_valid, o_ready, o_last, done;
  logic [63:0] o_word;

  mvu_rdc_reader dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_jump(cmd_jump), .cmd_len(cmd_len),
    .rdc_en(rdc_en), .rdc_addr(rdc_addr), .rdc_grnt(rdc_grnt), .rdc_word(rdc_word),
    .o_valid(o_valid), .o_ready(o_ready), .o_word(o_word), .o_last(o_last), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mw(input logic [14:0] a);
    return {a, 17'h1ABCD, 16'hC0DE, a, 1'b1};
  endfunction

  // Memory responder: word for an accepted address appears RDLAT cycles later.
  logic [63:0] m_p0, m_p1;
  always @(posedge clk) begin
    m_p0 <= (rdc_en && rdc_grnt) ? mw(rdc_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    m_p1 <= m_p0;
  end
  assign rdc_word = m_p1;

  int total = 0, bad = 0, cyc = 0;
  logic [14:0] cur_base, cur_jump, hold_addr;
  int cur_len, acc_k, pop_k, done_cnt, first_acc, last_acc, first_ov;
  bit en_seen, ov_seen, hold_pend;
  logic [14:0] addr_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] exp_a(input int k);
    return 15'(int'(cur_base) + k * int'(cur_jump));
  endfunction

  // Observe one cycle just after inputs settle, then advance to the next negedge.
  task automatic tick();
    #1;
    if (hold_pend) begin
      chk("hold_en", 64'(rdc_en), 64'(1));
      chk("hold_addr", 64'(rdc_addr), 64'(hold_addr));
    end
    hold_pend = 0;
    if (rdc_en) en_seen = 1;
    if (o_valid) begin
      ov_seen = 1;
      if (first_ov < 0) first_ov = cyc;
    end
    if (rdc_en && rdc_grnt) begin
      chk("rdc_addr", 64'(rdc_addr), 64'(exp_a(acc_k)));
      addr_log.push_back(rdc_addr);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      acc_k++;
    end else if (rdc_en) begin
      hold_pend = 1;
      hold_addr = rdc_addr;
    end
    if (o_valid && o_ready) begin
      chk("o_word", o_word, mw(exp_a(pop_k)));
      chk("o_last", 64'(o_last), 64'(pop_k == cur_len - 1));
      pop_k++;
    end
    if (done) begin
      done_cnt++;
      chk("done_at_last", 64'(pop_k), 64'(cur_len));
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input logic [14:0] b, input logic [14:0] j, input int l,
                     input int gp, input int rp, input int stall, input int stop_acc,
                     input int budget);
    int n;
    cur_base = b; cur_jump = j; cur_len = l;
    acc_k = 0; pop_k = 0; done_cnt = 0; en_seen = 0; ov_seen = 0; hold_pend = 0;
    first_acc = -1; last_acc = -1; first_ov = -1;
    addr_log.delete();
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1; cmd_base = b; cmd_jump = j; cmd_len = 16'(l);
    rdc_grnt = 0; o_ready = 0;
    tick();
    cmd_valid = 0;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'(l == 0));
    n = 0;
    while (done_cnt == 0 && n < budget && !(stop_acc > 0 && acc_k >= stop_acc)) begin
      if (stall > 0 && n == stall) begin
        chk("acc_at_full", 64'(acc_k), 64'(DEPTH));
        chk("en_at_full", 64'(rdc_en), 64'(0));
      end
      rdc_grnt = ($urandom_range(0, 99) < gp);
      o_ready  = (n < stall) ? 1'b0 : ($urandom_range(0, 99) < rp);
      tick();
      n++;
    end
    if (stop_acc > 0) return;
    chk("done_seen", 64'(done_cnt), 64'(1));
    chk("cmd_ready_after", 64'(cmd_ready), 64'(1));
    chk("o_valid_after", 64'(o_valid), 64'(0));
    rdc_grnt = 1; o_ready = 1;
    repeat (3) tick();
    chk("done_once", 64'(done_cnt), 64'(1));
    chk("acc_total", 64'(acc_k), 64'(l));
    chk("pop_total", 64'(pop_k), 64'(l));
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_base = '0; cmd_jump = '0; cmd_len = '0;
    rdc_grnt = 0; o_ready = 0;
    @(negedge clk);
    #1;
    chk("rst_en", 64'(rdc_en), 64'(0));
    chk("rst_addr", 64'(rdc_addr), 64'(0));
    chk("rst_ovalid", 64'(o_valid), 64'(0));
    chk("rst_olast", 64'(o_last), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Straight burst, full throughput.
    run(15'h0010, 15'd1, 4, 100, 100, 0, 0, 50);
    chk("a0", 64'(addr_log[0]), 64'h10);
    chk("a1", 64'(addr_log[1]), 64'h11);
    chk("a2", 64'(addr_log[2]), 64'h12);
    chk("a3", 64'(addr_log[3]), 64'h13);
    chk("back_to_back", 64'(last_acc - first_acc), 64'(3));
    chk("min_latency", 64'(first_ov - first_acc), 64'(RDLAT + 1));

    // Address wrap across 2^15.
    run(15'h7FFE, 15'd3, 3, 100, 100, 0, 0, 50);
    chk("wrap0", 64'(addr_log[0]), 64'h7FFE);
    chk("wrap1", 64'(addr_log[1]), 64'h0001);
    chk("wrap2", 64'(addr_log[2]), 64'h0004);

    // Output stalled: requests stop at FIFO capacity, then resume.
    run(15'h0100, 15'd2, 20, 100, 100, 20, 0, 200);

    // Random grant and backpressure.
    run(15'h0400, 15'd5, 50, 30, 50, 0, 0, 2000);
    run(15'h7FF0, 15'd7, 13, 60, 30, 0, 0, 2000);

    // Zero-length command.
    run(15'h0123, 15'd1, 0, 100, 100, 0, 0, 10);
    chk("len0_no_en", 64'(en_seen), 64'(0));
    chk("len0_no_ovalid", 64'(ov_seen), 64'(0));

    // Reset mid-burst; stale returns must not leak into the next burst.
    run(15'h0200, 15'd1, 10, 100, 0, 0, 3, 100);
    chk("pre_rst_acc", 64'(acc_k), 64'(3));
    rst_n = 0;
    #1;
    chk("mid_rst_en", 64'(rdc_en), 64'(0));
    chk("mid_rst_addr", 64'(rdc_addr), 64'(0));
    chk("mid_rst_ovalid", 64'(o_valid), 64'(0));
    chk("mid_rst_olast", 64'(o_last), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1;
    run(15'h0300, 15'd2, 2, 100, 100, 0, 0, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
